// File: rtl/snk68_input_pkg.sv
// ---------------------------------------------------------------------------
// snk68_input_pkg
//  Shared types and helpers for the SNK68 input-conditioning blocks.
//  - rot_state_t : rotary auto-repeat controller states
//  - dir_t       : resolved rotate direction (two raw levels -> one request)
//  - ms_div      : system clocks per millisecond, used to size the prescaler
//  - decode_dir  : maps raw {cw, ccw} to a direction; both pressed means none
// ---------------------------------------------------------------------------
package snk68_input_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESS, REPEAT} rot_state_t;

  typedef enum logic [1:0] {NONE, CW, CCW} dir_t;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Conflicting requests (both buttons) cancel out rather than picking a winner.
  function automatic dir_t decode_dir(input logic cw, input logic ccw);
    case ({cw, ccw})
      2'b10:   return CW;
      2'b01:   return CCW;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/snk68_ms_tick.sv
// ---------------------------------------------------------------------------
// snk68_ms_tick
//  Free-running millisecond prescaler. Counts 0..DIV-1 and raises tick for
//  one cycle while sitting at the terminal count. hold freezes the count and
//  masks the tick, so everything timed from it pauses cleanly.
//  Ports:
//   clk_sys  in  system clock
//   reset_n  in  asynchronous active-low reset
//   hold     in  1 = freeze count, no tick
//   tick     out one-cycle pulse once per DIV unheld cycles
// ---------------------------------------------------------------------------
module snk68_ms_tick #(
  parameter int DIV = 72_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic hold,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == TERM) ? '0 : count + PW'(1);
    end
  end

  // Combinational so the consumer acts on the same edge the prescaler wraps.
  assign tick = !hold && (count == TERM);

endmodule

// File: rtl/rotary_autorepeat.sv
// ---------------------------------------------------------------------------
// rotary_autorepeat
//  Conditions the raw rotate-button levels for the SNK68 rotary joystick
//  emulation: synchronise, debounce, resolve direction, then emit one-cycle
//  step pulses with a typematic delay followed by a steady repeat rate.
//  Ports:
//   clk_sys   in  system clock
//   reset_n   in  asynchronous active-low reset
//   pause     in  1 = freeze prescaler, counters and state; no pulses
//   cw_in     in  raw clockwise request level (asynchronous)
//   ccw_in    in  raw anticlockwise request level (asynchronous)
//   step_cw   out one-cycle pulse: advance one position clockwise
//   step_ccw  out one-cycle pulse: advance one position anticlockwise
//   busy      out 1 while a direction is held and accepted (PRESS/REPEAT)
// ---------------------------------------------------------------------------
module rotary_autorepeat
  import snk68_input_pkg::*;
#(
  parameter int CLK_HZ      = 72_000_000,
  parameter int DEBOUNCE_MS = 5,
  parameter int DELAY_MS    = 250,
  parameter int REPEAT_MS   = 60
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pause,
  input  logic cw_in,
  input  logic ccw_in,
  output logic step_cw,
  output logic step_ccw,
  output logic busy
);

  localparam int MAX_AB = (DEBOUNCE_MS > DELAY_MS) ? DEBOUNCE_MS : DELAY_MS;
  localparam int MAX_MS = (MAX_AB > REPEAT_MS) ? MAX_AB : REPEAT_MS;
  localparam int CNT_W  = $clog2(MAX_MS + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_MS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_MS - 1);

  if (CLK_HZ < 1000 || DEBOUNCE_MS < 1 || DELAY_MS < 1 || REPEAT_MS < 1) begin : g_bad_params
    $error("rotary_autorepeat: CLK_HZ must give >= 1 cycle/ms and all *_MS must be non-zero");
  end

  logic cw_meta, cw_sync;
  logic ccw_meta, ccw_sync;
  logic tick;
  dir_t dir;

  rot_state_t       state;
  dir_t             cand;
  logic [CNT_W-1:0] ms_count;

  // Two-flop synchronisers on the raw button levels.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cw_meta  <= 1'b0;
      cw_sync  <= 1'b0;
      ccw_meta <= 1'b0;
      ccw_sync <= 1'b0;
    end else begin
      cw_meta  <= cw_in;
      cw_sync  <= cw_meta;
      ccw_meta <= ccw_in;
      ccw_sync <= ccw_meta;
    end
  end

  assign dir = decode_dir(cw_sync, ccw_sync);

  snk68_ms_tick #(
    .DIV(ms_div(CLK_HZ))
  ) u_ms_tick (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .hold   (pause),
    .tick   (tick)
  );

  // Controller. Any disagreement between the live direction and the latched
  // candidate drops straight back to IDLE and takes priority over a pulse that
  // would otherwise fire on the same edge, so a release never produces a late
  // step and a reversal always has to re-qualify through DEBOUNCE.
  // While paused the whole controller holds; only the pulses are cleared.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cand     <= NONE;
      ms_count <= '0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      busy     <= 1'b0;
    end else if (pause) begin
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
    end else begin
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      case (state)
        IDLE: begin
          if (dir != NONE) begin
            state    <= DEBOUNCE;
            cand     <= dir;
            ms_count <= '0;
          end
        end
        DEBOUNCE: begin
          if (dir != cand) begin
            state    <= IDLE;
            ms_count <= '0;
          end else if (tick) begin
            if (ms_count == DEB_LAST) begin
              state    <= PRESS;
              ms_count <= '0;
              busy     <= 1'b1;
              step_cw  <= (cand == CW);
              step_ccw <= (cand == CCW);
            end else begin
              ms_count <= ms_count + CNT_W'(1);
            end
          end
        end
        PRESS: begin
          if (dir != cand) begin
            state    <= IDLE;
            ms_count <= '0;
            busy     <= 1'b0;
          end else if (tick) begin
            if (ms_count == DLY_LAST) begin
              state    <= REPEAT;
              ms_count <= '0;
              step_cw  <= (cand == CW);
              step_ccw <= (cand == CCW);
            end else begin
              ms_count <= ms_count + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (dir != cand) begin
            state    <= IDLE;
            ms_count <= '0;
            busy     <= 1'b0;
          end else if (tick) begin
            if (ms_count == RPT_LAST) begin
              ms_count <= '0;
              step_cw  <= (cand == CW);
              step_ccw <= (cand == CCW);
            end else begin
              ms_count <= ms_count + CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          ms_count <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_autorepeat.sv
// ---------------------------------------------------------------------------
// tb_rotary_autorepeat
//  Scenario bench for rotary_autorepeat at 8 clocks per ms with a 2 ms
//  debounce, 10 ms typematic delay and 4 ms repeat. Expected pulse timing is
//  computed from the ms figures: the first step lands DEBOUNCE ms of ticks
//  after the synchronised request (free-running prescaler phase gives a
//  one-ms window), then steps follow at DELAY and DELAY+k*REPEAT ms.
// ---------------------------------------------------------------------------
module tb_rotary_autorepeat;

  localparam int CLK_HZ = 8000;
  localparam int DEB    = 2;
  localparam int DLY    = 10;
  localparam int RPT    = 4;
  localparam int CPM    = CLK_HZ / 1000;
  // Request to first step: 2 sync edges + 1 edge into debounce, then DEB ticks
  // with the first tick 1..CPM edges away.
  localparam int LAT_MIN = 3 + 1 + (DEB - 1) * CPM;
  localparam int LAT_MAX = 3 + CPM + (DEB - 1) * CPM;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic pause   = 1'b0;
  logic cw_in   = 1'b0;
  logic ccw_in  = 1'b0;
  logic step_cw, step_ccw, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ucyc   = 0;
  int cw_q[$];
  int cw_uq[$];
  int ccw_q[$];
  int exp_q[$];
  int both_cnt, busy_hi, busy_lo, paused_pulse;

  always #5 clk_sys = ~clk_sys;

  rotary_autorepeat #(
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DEB),
    .DELAY_MS   (DLY),
    .REPEAT_MS  (RPT)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .pause   (pause),
    .cw_in   (cw_in),
    .ccw_in  (ccw_in),
    .step_cw (step_cw),
    .step_ccw(step_ccw),
    .busy    (busy)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_logs();
    cw_q.delete();
    cw_uq.delete();
    ccw_q.delete();
    both_cnt     = 0;
    busy_hi      = 0;
    busy_lo      = 0;
    paused_pulse = 0;
  endtask

  // Advance one clock and log what the outputs show just after the edge.
  task automatic cycle();
    logic p;
    p = pause;
    @(posedge clk_sys);
    #1;
    cyc++;
    if (!p) ucyc++;
    if (step_cw) begin
      cw_q.push_back(cyc);
      cw_uq.push_back(ucyc);
    end
    if (step_ccw) ccw_q.push_back(cyc);
    if (step_cw && step_ccw) both_cnt++;
    if ((step_cw || step_ccw) && p) paused_pulse++;
    if (busy) busy_hi++;
    else busy_lo++;
  endtask

  task automatic run_until(input int want, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      cycle();
      if (cw_q.size() + ccw_q.size() >= want) hit = 1'b1;
    end
  endtask

  task automatic settle();
    cw_in  = 1'b0;
    ccw_in = 1'b0;
    repeat (4 * CPM) cycle();
  endtask

  // Offsets (cycles from the first step) of every step expected while held.
  task automatic build_expected(input int last);
    exp_q.delete();
    exp_q.push_back(0);
    for (int r = DLY * CPM; r <= last; r += RPT * CPM) exp_q.push_back(r);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) cycle();
    checks++;
    if (step_cw !== 1'b0) begin errors++; $display("[TB] FAIL reset_step_cw: got %b, expected 0", step_cw); end
    checks++;
    if (step_ccw !== 1'b0) begin errors++; $display("[TB] FAIL reset_step_ccw: got %b, expected 0", step_ccw); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    reset_n = 1'b1;
    clear_logs();
    repeat (5 * CPM) cycle();
    checks++;
    if (cw_q.size() + ccw_q.size() != 0 || busy_hi != 0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %0d pulses busy_hi=%0d, expected 0/0", cw_q.size() + ccw_q.size(), busy_hi);
    end
  endtask

  // Hold one direction for n cycles after its first step, then release.
  task automatic do_hold(input bit use_ccw, input int n, input string tag);
    int k, fp, lat;
    bit hit;
    int got[$];
    clear_logs();
    if (use_ccw) ccw_in = 1'b1;
    else cw_in = 1'b1;
    k = cyc;
    run_until(1, LAT_MAX + 8, hit);
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL %s_first: got no step in %0d cycles, expected one", tag, LAT_MAX + 8);
      settle();
      return;
    end
    fp  = cyc;
    lat = cyc - k;
    checks++;
    if (lat < LAT_MIN || lat > LAT_MAX) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d cycles, expected %0d..%0d", tag, lat, LAT_MIN, LAT_MAX);
    end
    busy_lo = busy ? 0 : 1;
    repeat (n) cycle();
    cw_in  = 1'b0;
    ccw_in = 1'b0;
    repeat (2) cycle();
    checks++;
    if (busy_lo != 0) begin errors++; $display("[TB] FAIL %s_busy_held: got %0d low cycles, expected 0", tag, busy_lo); end
    repeat (4 * CPM) cycle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_release: got %b, expected 0", tag, busy); end
    build_expected(n + 2);
    if (use_ccw) got = ccw_q;
    else got = cw_q;
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d steps, expected %0d (hold %0d cycles)", tag, got.size(), exp_q.size(), n);
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] - fp != exp_q[i]) begin
          errors++;
          $display("[TB] FAIL %s_time%0d: got offset %0d, expected %0d", tag, i, got[i] - fp, exp_q[i]);
        end
      end
    end
    checks++;
    if ((use_ccw ? cw_q.size() : ccw_q.size()) != 0 || both_cnt != 0) begin
      errors++;
      $display("[TB] FAIL %s_other_dir: got %0d wrong-direction steps, %0d overlaps, expected 0", tag,
               use_ccw ? cw_q.size() : ccw_q.size(), both_cnt);
    end
  endtask

  task automatic test_hold_repeat();
    do_hold(1'b0, 30 * CPM, "hold30");
  endtask

  task automatic test_reset_mid_repeat();
    bit hit;
    int k;
    clear_logs();
    cw_in = 1'b1;
    run_until(2, DLY * CPM + LAT_MAX + 8, hit);
    checks++;
    if (!hit || cw_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL rst_reach_repeat: got %0d steps, expected 2", cw_q.size());
    end else begin
      checks++;
      if (cw_q[1] - cw_q[0] != DLY * CPM) begin
        errors++;
        $display("[TB] FAIL rst_first_repeat: got gap %0d, expected %0d", cw_q[1] - cw_q[0], DLY * CPM);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (step_cw !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_async: got step_cw=%b busy=%b, expected 0/0", step_cw, busy);
    end
    repeat (3) cycle();
    reset_n = 1'b1;
    clear_logs();
    k = cyc;
    run_until(1, LAT_MAX + 8, hit);
    checks++;
    if (!hit || cw_q.size() != 1 || cyc - k != DEB * CPM) begin
      errors++;
      $display("[TB] FAIL rst_requalify: got step after %0d cycles (hit=%0d), expected %0d", cyc - k, hit, DEB * CPM);
    end
    settle();
  endtask

  task automatic test_glitch();
    int len;
    for (int g = 0; g < 3; g++) begin
      repeat ($urandom_range(0, CPM - 1)) cycle();
      len = $urandom_range(1, CPM);
      clear_logs();
      cw_in = 1'b1;
      repeat (len) cycle();
      cw_in = 1'b0;
      repeat (5 * CPM) cycle();
      checks++;
      if (cw_q.size() + ccw_q.size() != 0 || busy_hi != 0) begin
        errors++;
        $display("[TB] FAIL glitch_%0d: got %0d steps busy_hi=%0d for %0d-cycle glitch, expected 0/0",
                 g, cw_q.size() + ccw_q.size(), busy_hi, len);
      end
    end
  endtask

  task automatic test_both_pressed();
    bit hit;
    int k;
    clear_logs();
    cw_in  = 1'b1;
    ccw_in = 1'b1;
    repeat (20 * CPM) cycle();
    checks++;
    if (cw_q.size() + ccw_q.size() != 0 || busy_hi != 0) begin
      errors++;
      $display("[TB] FAIL both_quiet: got %0d steps busy_hi=%0d, expected 0/0", cw_q.size() + ccw_q.size(), busy_hi);
    end
    ccw_in = 1'b0;
    k = cyc;
    clear_logs();
    run_until(1, LAT_MAX + 8, hit);
    checks++;
    if (!hit || cw_q.size() != 1 || cyc - k < LAT_MIN || cyc - k > LAT_MAX) begin
      errors++;
      $display("[TB] FAIL both_drop_ccw: got cw steps=%0d after %0d cycles, expected 1 in %0d..%0d",
               cw_q.size(), cyc - k, LAT_MIN, LAT_MAX);
    end
    settle();
  endtask

  task automatic test_reversal();
    bit hit;
    int k;
    clear_logs();
    cw_in = 1'b1;
    run_until(2, DLY * CPM + LAT_MAX + 8, hit);
    repeat (10) cycle();
    clear_logs();
    cw_in  = 1'b0;
    ccw_in = 1'b1;
    k = cyc;
    run_until(1, LAT_MAX + 10, hit);
    checks++;
    if (!hit || ccw_q.size() != 1 || cw_q.size() != 0 || cyc - k < LAT_MIN + 1 || cyc - k > LAT_MAX + 1) begin
      errors++;
      $display("[TB] FAIL rev_first_ccw: got ccw=%0d cw=%0d after %0d cycles, expected 1/0 in %0d..%0d",
               ccw_q.size(), cw_q.size(), cyc - k, LAT_MIN + 1, LAT_MAX + 1);
    end
    run_until(2, DLY * CPM + 4, hit);
    checks++;
    if (ccw_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL rev_second_ccw: got %0d ccw steps, expected 2", ccw_q.size());
    end else begin
      checks++;
      if (ccw_q[1] - ccw_q[0] != DLY * CPM) begin
        errors++;
        $display("[TB] FAIL rev_delay: got gap %0d, expected %0d", ccw_q[1] - ccw_q[0], DLY * CPM);
      end
    end
    checks++;
    if (cw_q.size() != 0 || both_cnt != 0) begin
      errors++;
      $display("[TB] FAIL rev_no_cw: got %0d cw steps %0d overlaps, expected 0/0", cw_q.size(), both_cnt);
    end
    settle();
  endtask

  task automatic test_pause();
    bit hit;
    clear_logs();
    cw_in = 1'b1;
    run_until(1, LAT_MAX + 8, hit);
    repeat ($urandom_range(8, 40)) cycle();
    pause        = 1'b1;
    busy_lo      = 0;
    paused_pulse = 0;
    repeat (7 * CPM) cycle();
    pause = 1'b0;
    checks++;
    if (paused_pulse != 0 || busy_lo != 0) begin
      errors++;
      $display("[TB] FAIL pause_hold: got %0d paused steps busy_lo=%0d, expected 0/0", paused_pulse, busy_lo);
    end
    run_until(2, DLY * CPM + 8, hit);
    checks++;
    if (cw_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL pause_repeat: got %0d steps, expected 2", cw_q.size());
    end else begin
      checks++;
      if (cw_uq[1] - cw_uq[0] != DLY * CPM || cw_q[1] - cw_q[0] != (DLY + 7) * CPM) begin
        errors++;
        $display("[TB] FAIL pause_timing: got unpaused gap %0d total gap %0d, expected %0d/%0d",
                 cw_uq[1] - cw_uq[0], cw_q[1] - cw_q[0], DLY * CPM, (DLY + 7) * CPM);
      end
    end
    settle();
  endtask

  task automatic test_random_holds();
    for (int t = 0; t < 5; t++) begin
      repeat ($urandom_range(0, 2 * CPM)) cycle();
      do_hold(1'($urandom_range(0, 1)), $urandom_range(0, 40 * CPM), $sformatf("rand%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_reset_mid_repeat();
    test_glitch();
    test_both_pressed();
    test_reversal();
    test_pause();
    test_random_holds();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
